dvp_gray_pipe: RTL and testbench

// - Consumes the 16-bit RGB565 pixel stream produced by cmos_capture_data and converts it to 8-bit luma.
// - Keeps vsync/href aligned to the converted pixels and produces pixel x/y coordinates plus a frame-start pulse.
// - Checks line length and frame height, and raises sticky error flags when they do not match.
// - Feeds the frame-buffer writer and frame-difference stage.

---
 rtl/dvp_pkg.sv | 28 ++
 rtl/rgb565_to_y.sv | 81 ++++++++
 rtl/dvp_gray_pipe.sv | 151 +++++++++++++++
 tb/tb_dvp_gray_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP grayscale path.
//   Y_KR/Y_KG/Y_KB : BT.601-style luma weights scaled by 256
//   LAT_GRAY       : clock cycles from pixel input to luma output
//   dvp_sync_t     : the three sync/strobe bits that travel with a pixel
//   expand5/6      : widen a 5- or 6-bit colour field to 8 bits by repeating its MSBs
package dvp_pkg;

    localparam logic [7:0] Y_KR = 8'd77;
    localparam logic [7:0] Y_KG = 8'd150;
    localparam logic [7:0] Y_KB = 8'd29;

    localparam int LAT_GRAY = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic valid;
    } dvp_sync_t;

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/rgb565_to_y.sv
// Three-stage RGB565 -> 8-bit luma converter with sync bits carried alongside.
//   clk      : pixel clock
//   rst_n    : asynchronous active-low reset
//   sync_in  : vsync/href/valid of the incoming pixel
//   pix      : RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   sync_out : sync_in delayed LAT_GRAY cycles
//   luma     : (77*R8 + 150*G8 + 29*B8) >> 8, aligned with sync_out
module rgb565_to_y
    import dvp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  dvp_sync_t   sync_in,
    input  logic [15:0] pix,
    output dvp_sync_t   sync_out,
    output logic [7:0]  luma
);

    logic [7:0]  r8_s;
    logic [7:0]  g8_s;
    logic [7:0]  b8_s;
    logic [15:0] prod_r_r;
    logic [15:0] prod_g_r;
    logic [15:0] prod_b_r;
    logic [15:0] sum_r;
    logic [7:0]  luma_r;
    dvp_sync_t   sync_r [LAT_GRAY];

    assign r8_s = expand5(pix[15:11]);
    assign g8_s = expand6(pix[10:5]);
    assign b8_s = expand5(pix[4:0]);

    // Stage 1: weighted colour products (each fits 16 bits, as does their sum).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r_r <= 16'd0;
            prod_g_r <= 16'd0;
            prod_b_r <= 16'd0;
        end else begin
            prod_r_r <= 16'(Y_KR) * 16'(r8_s);
            prod_g_r <= 16'(Y_KG) * 16'(g8_s);
            prod_b_r <= 16'(Y_KB) * 16'(b8_s);
        end
    end

    // Stage 2: sum of products, max 65280 so no carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'd0;
        end else begin
            sum_r <= prod_r_r + prod_g_r + prod_b_r;
        end
    end

    // Stage 3: divide by 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_r <= 8'd0;
        end else begin
            luma_r <= sum_r[15:8];
        end
    end

    // Sync shift register matching the arithmetic latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT_GRAY; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= sync_in;
            for (int i = 1; i < LAT_GRAY; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_out = sync_r[LAT_GRAY-1];
    assign luma     = luma_r;

endmodule

// File: rtl/dvp_gray_pipe.sv
// RGB565 capture stream -> 8-bit luma with coordinates and frame/line checks.
//   ov5640_pclk, rst_n                 : clock, async active-low reset
//   in_vsync/in_href/in_valid/in_data  : capture-stage stream
//   gray_vsync/gray_href/gray_valid    : inputs delayed 3 cycles
//   gray_data                          : luma of the pixel on gray_valid
//   pix_x/pix_y                        : column/row of that pixel
//   frame_start                        : pulse one cycle after gray_vsync rises
//   line_err/frame_err                 : sticky length-mismatch flags, cleared by frame_start
module dvp_gray_pipe
    import dvp_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 12,
    parameter int YW    = 12
) (
    input  logic          ov5640_pclk,
    input  logic          rst_n,
    input  logic          in_vsync,
    input  logic          in_href,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    output logic          gray_vsync,
    output logic          gray_href,
    output logic          gray_valid,
    output logic [7:0]    gray_data,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          line_err,
    output logic          frame_err
);

    localparam logic [XW-1:0] X_MAX     = '1;
    localparam logic [YW-1:0] Y_MAX     = '1;
    localparam logic [XW:0]   LINE_LEN  = (XW+1)'(IMG_W);
    localparam logic [YW-1:0] FRAME_LEN = YW'(IMG_H);

    dvp_sync_t     sync_in_s;
    dvp_sync_t     sync_out_s;
    logic          vsync_d_r;
    logic          href_d_r;
    logic          vsync_rise_s;
    logic          href_fall_s;
    logic [XW:0]   line_len_s;
    logic          line_bad_s;
    logic          frame_bad_s;
    logic [XW-1:0] x_cnt_r;
    logic [YW-1:0] y_cnt_r;
    logic          first_frame_r;
    logic          frame_start_r;
    logic          line_err_r;
    logic          frame_err_r;

    assign sync_in_s = {in_vsync, in_href, in_valid};

    rgb565_to_y u_conv (
        .clk      (ov5640_pclk),
        .rst_n    (rst_n),
        .sync_in  (sync_in_s),
        .pix      (in_data),
        .sync_out (sync_out_s),
        .luma     (gray_data)
    );

    assign vsync_rise_s = sync_out_s.vsync & ~vsync_d_r;
    assign href_fall_s  = href_d_r & ~sync_out_s.href;

    // A pixel strobed on the very cycle href drops still belongs to the line.
    assign line_len_s  = {1'b0, x_cnt_r} + {{XW{1'b0}}, sync_out_s.valid};
    assign line_bad_s  = href_fall_s & ((x_cnt_r == X_MAX) | (line_len_s != LINE_LEN));
    assign frame_bad_s = vsync_rise_s & ~first_frame_r &
                         ((y_cnt_r == Y_MAX) | (y_cnt_r != FRAME_LEN));

    // One-cycle copies of the output syncs for edge detection.
    always_ff @(posedge ov5640_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= sync_out_s.vsync;
            href_d_r  <= sync_out_s.href;
        end
    end

    // Pixel/line counters; vsync rise takes priority, counts saturate.
    always_ff @(posedge ov5640_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_r <= '0;
            y_cnt_r <= '0;
        end else if (vsync_rise_s) begin
            x_cnt_r <= '0;
            y_cnt_r <= '0;
        end else if (href_fall_s) begin
            x_cnt_r <= '0;
            y_cnt_r <= (y_cnt_r == Y_MAX) ? y_cnt_r : y_cnt_r + YW'(1);
        end else if (sync_out_s.valid) begin
            x_cnt_r <= (x_cnt_r == X_MAX) ? x_cnt_r : x_cnt_r + XW'(1);
        end else begin
            x_cnt_r <= x_cnt_r;
        end
    end

    // Frame bookkeeping: the first vsync after reset only arms the frame check.
    always_ff @(posedge ov5640_pclk or negedge rst_n) begin
        if (!rst_n) begin
            first_frame_r <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= vsync_rise_s;
            if (vsync_rise_s) begin
                first_frame_r <= 1'b0;
            end else begin
                first_frame_r <= first_frame_r;
            end
        end
    end

    // Sticky error flags; a new error outranks the frame_start clear.
    always_ff @(posedge ov5640_pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_err_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (line_bad_s) begin
                line_err_r <= 1'b1;
            end else if (frame_start_r) begin
                line_err_r <= 1'b0;
            end else begin
                line_err_r <= line_err_r;
            end
            if (frame_bad_s) begin
                frame_err_r <= 1'b1;
            end else if (frame_start_r) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign gray_vsync  = sync_out_s.vsync;
    assign gray_href   = sync_out_s.href;
    assign gray_valid  = sync_out_s.valid;
    assign pix_x       = x_cnt_r;
    assign pix_y       = y_cnt_r;
    assign frame_start = frame_start_r;
    assign line_err    = line_err_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_dvp_gray_pipe.sv
module tb_dvp_gray_pipe;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int XMAX = 4095;
    localparam int YMAX = 4095;

    logic        clk;
    logic        rst_n;
    logic        in_vsync;
    logic        in_href;
    logic        in_valid;
    logic [15:0] in_data;
    logic        gray_vsync;
    logic        gray_href;
    logic        gray_valid;
    logic [7:0]  gray_data;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;
    logic        line_err;
    logic        frame_err;

    int checks;
    int errors;

    dvp_gray_pipe #(.IMG_W(W), .IMG_H(H), .XW(12), .YW(12)) dut (
        .ov5640_pclk (clk),
        .rst_n       (rst_n),
        .in_vsync    (in_vsync),
        .in_href     (in_href),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .gray_vsync  (gray_vsync),
        .gray_href   (gray_href),
        .gray_valid  (gray_valid),
        .gray_data   (gray_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Luma straight from the colour-expansion and weighting rules.
    function automatic int luma(input int d);
        int r, g, b, r8, g8, b8;
        r  = (d >> 11) & 31;
        g  = (d >> 5) & 63;
        b  = d & 31;
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    // Reference model: 3-deep input history plus counters/flags; checked every negedge.
    initial begin
        int hv[3], hh[3], hl[3], hd[3];
        int mx, my, pvs, phr, ff, fs, le, fe;
        int vr, hf, lb, fb;
        ff = 1; mx = 0; my = 0; pvs = 0; phr = 0; fs = 0; le = 0; fe = 0;
        for (int i = 0; i < 3; i++) begin hv[i] = 0; hh[i] = 0; hl[i] = 0; hd[i] = 0; end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ff = 1; mx = 0; my = 0; pvs = 0; phr = 0; fs = 0; le = 0; fe = 0;
                for (int i = 0; i < 3; i++) begin hv[i] = 0; hh[i] = 0; hl[i] = 0; hd[i] = 0; end
            end
            chk("gray_vsync", gray_vsync, hv[2]);
            chk("gray_href", gray_href, hh[2]);
            chk("gray_valid", gray_valid, hl[2]);
            if (hl[2] != 0) begin
                chk("gray_data", gray_data, luma(hd[2]));
                chk("pix_x", pix_x, mx);
                chk("pix_y", pix_y, my);
            end
            chk("frame_start", frame_start, fs);
            chk("line_err", line_err, le);
            chk("frame_err", frame_err, fe);
            if (rst_n) begin
                vr = (hv[2] != 0 && pvs == 0) ? 1 : 0;
                hf = (phr != 0 && hh[2] == 0) ? 1 : 0;
                lb = (hf != 0 && (mx == XMAX || mx + hl[2] != W)) ? 1 : 0;
                fb = (vr != 0 && ff == 0 && (my == YMAX || my != H)) ? 1 : 0;
                le = lb ? 1 : (fs ? 0 : le);
                fe = fb ? 1 : (fs ? 0 : fe);
                fs = vr;
                if (vr != 0) ff = 0;
                if (vr != 0) begin
                    mx = 0; my = 0;
                end else if (hf != 0) begin
                    mx = 0; my = (my < YMAX) ? my + 1 : YMAX;
                end else if (hl[2] != 0) begin
                    mx = (mx < XMAX) ? mx + 1 : XMAX;
                end
                pvs = hv[2]; phr = hh[2];
                for (int i = 2; i > 0; i--) begin
                    hv[i] = hv[i-1]; hh[i] = hh[i-1]; hl[i] = hl[i-1]; hd[i] = hd[i-1];
                end
                hv[0] = in_vsync; hh[0] = in_href; hl[0] = in_valid; hd[0] = in_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_vsync"}, gray_vsync, 0);
        chk({tag, "_href"}, gray_href, 0);
        chk({tag, "_valid"}, gray_valid, 0);
        chk({tag, "_data"}, gray_data, 0);
        chk({tag, "_x"}, pix_x, 0);
        chk({tag, "_y"}, pix_y, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_lerr"}, line_err, 0);
        chk({tag, "_ferr"}, frame_err, 0);
    endtask

    task automatic pixel_lit(input logic [15:0] d, input int exp);
        chk("model_luma", luma(int'(d)), exp);
        in_valid = 1'b1; in_data = d;
        tick(1);
        in_valid = 1'b0;
        tick(2);
        chk("lit_valid", gray_valid, 1);
        chk("lit_data", gray_data, exp);
    endtask

    // One line; returns 4 cycles after href drops, when line_err has settled.
    task automatic send_line(input int npix, input int rnd_gap);
        in_href = 1'b1;
        tick(1);
        for (int p = 0; p < npix; p++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick(1);
            in_valid = 1'b0;
            tick(rnd_gap != 0 ? int'($urandom_range(1, 2)) : 1);
        end
        in_href = 1'b0;
        tick(4);
    endtask

    // vsync pulse; exp_fe < 0 skips the literal frame_err expectation.
    task automatic vsync_pulse(input int exp_fe);
        in_vsync = 1'b1;
        tick(4);
        chk("vs_frame_start", frame_start, 1);
        if (exp_fe >= 0) chk("vs_frame_err", frame_err, exp_fe);
        in_vsync = 1'b0;
        tick(1);
        chk("vs_ferr_cleared", frame_err, 0);
        chk("vs_lerr_cleared", line_err, 0);
        tick(2);
    endtask

    initial begin
        int nl;
        int exp_fe;
        checks = 0; errors = 0;
        in_vsync = 1'b0; in_href = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Single-pixel luma literals.
        pixel_lit(16'hFFFF, 255);
        pixel_lit(16'hF800, 76);
        pixel_lit(16'h07E0, 149);
        pixel_lit(16'h001F, 28);
        pixel_lit(16'h0000, 0);
        tick(2);

        // Partial frame before the first vsync: 3 lines, not checked.
        for (int l = 0; l < 3; l++) send_line(W, 0);
        vsync_pulse(0);

        // Clean 4x8 frame.
        for (int l = 0; l < H; l++) begin
            send_line(W, 0);
            chk("good_line_err", line_err, 0);
        end
        vsync_pulse(0);

        // Frame with a 7-pixel line; flag stays until frame_start.
        send_line(W, 0);
        chk("pre_short_lerr", line_err, 0);
        send_line(W - 1, 0);
        chk("short_lerr", line_err, 1);
        send_line(W, 0);
        chk("short_lerr_sticky", line_err, 1);
        send_line(W, 0);
        chk("short_lerr_sticky2", line_err, 1);
        vsync_pulse(0);

        // Clean frame leaves flags at 0.
        for (int l = 0; l < H; l++) begin
            send_line(W, 0);
            chk("clean_line_err", line_err, 0);
        end
        vsync_pulse(0);

        // 3-line frame after a good one.
        for (int l = 0; l < 3; l++) send_line(W, 0);
        vsync_pulse(1);

        // vsync rising in mid-line after pixel 4.
        in_href = 1'b1;
        tick(1);
        for (int p = 0; p < 4; p++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick(1);
            in_valid = 1'b0;
            tick(1);
        end
        in_vsync = 1'b1;
        tick(1);
        in_valid = 1'b1; in_data = 16'h1234;
        tick(1);
        in_valid = 1'b0;
        tick(2);
        chk("midline_valid", gray_valid, 1);
        chk("midline_x", pix_x, 0);
        chk("midline_y", pix_y, 0);
        in_vsync = 1'b0;
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick(1);
            in_valid = 1'b0;
            tick(1);
        end
        in_href = 1'b0;
        tick(4);
        chk("midline_lerr", line_err, 1);
        for (int l = 0; l < 3; l++) send_line(W, 0);
        vsync_pulse(0);

        // Randomized frames.
        for (int f = 0; f < 5; f++) begin
            nl = int'($urandom_range(3, 5));
            for (int l = 0; l < nl; l++) send_line(int'($urandom_range(W - 1, W + 1)), 1);
            exp_fe = (nl != H) ? 1 : 0;
            vsync_pulse(exp_fe);
        end

        // Asynchronous reset mid-line.
        in_href = 1'b1;
        tick(1);
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick(1);
        end
        #2 rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        in_valid = 1'b0; in_href = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            chk("flush_valid", gray_valid, 0);
        end

        // Partial frame after reset is not checked.
        for (int l = 0; l < 2; l++) send_line(W, 1);
        vsync_pulse(0);
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
